posit64_decode_arbiter: RTL and testbench
=========================================

# posit64_decode_arbiter

Shares one 64-bit posit decode datapath among `NREQ` independent requesters. Each requester issues posit operands over a valid/ready handshake. The block grants the decoder round-robin, pipelines the operand through a registered decode, and returns sign/regime/exponent/fraction to a single tagged response port. It sits between the operand-fetch front end and the posit arithmetic units.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..16).
- `ES`, 2: posit exponent size, passed to the decode datapath.
- `IDW`, `$clog2(NREQ)`: response tag width (derived, not overridable).

Ports:
- `clk`  in  1  single clock; all state is updated on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous pipeline clear; the arbitration pointer is kept.
- `req_valid`  in  NREQ  per-requester operand valid.
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero.
- `req_p`  in  NREQ x 64  per-requester `posit64_t` operand.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  downstream accept.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_sign`  out  1  decoded sign (`sign_t`).
- `rsp_regime`  out  64 signed  regime k.
- `rsp_exponent`  out  64 signed  exponent field.
- `rsp_fraction`  out  64 unsigned  fraction, left-aligned, hidden bit excluded.
- `rsp_zero`  out  1  operand was 0x0000_0000_0000_0000.
- `rsp_nar`  out  1  operand was NaR, 0x8000_0000_0000_0000.

## Operation
Pipeline:
- S1 is the operand register: `s1_valid`, `s1_p`, `s1_id`.
- S2 is the output register; it drives every `rsp_*` port.
- Decode logic is combinational between S1 and S2.

Stage advance:
- `s2_take = !rsp_valid || rsp_ready`.
- `s1_take = !s1_valid || s2_take`.
- When `s2_take` holds, S2 loads from S1: `rsp_valid <= s1_valid`.

Arbitration:
- Round-robin over `req_valid`, starting the search at pointer `prio`.
- The grant is combinational. `req_ready[g]` is high only for the granted index g, and only when `s1_take` is high.
- The handshake completes when `req_valid[g] && req_ready[g]`. S1 then loads `req_p[g]` and `g`, and `prio <= (g+1) mod NREQ`.
- `prio` is unchanged when there is no handshake.
- If no request is valid and `s1_take` holds, `s1_valid <= 0`.

Special values:
- `rsp_zero` and `rsp_nar` are computed from `s1_p`.
- For zero or NaR, `rsp_regime`, `rsp_exponent` and `rsp_fraction` are 0. `rsp_sign` is the raw MSB.

Stall rule:
- While `rsp_valid && !rsp_ready`, all `rsp_*` outputs hold stable.
- S1 holds if it is occupied.

Flush:
- Clears `s1_valid` and `rsp_valid` at the next edge.
- No `req_ready` is asserted during the flush cycle.
- `prio` is unchanged.

Reset:
- `s1_valid`, `rsp_valid` and `prio` go to 0.
- All `rsp_*` data and `rsp_id` go to 0.
- `req_ready` is 0 while `rst` is high.
- Reset mid-transfer drops in-flight operands; no response is emitted for them.

Simultaneous events:
- `rst` has priority over `flush`.
- `flush` has priority over a concurrent handshake; the operand is not accepted.

## Timing
- Latency: operand accepted at edge k gives `rsp_valid` high after edge k+1, so the response can be consumed at edge k+2.
- Throughput: one operand per cycle while `rsp_ready` is held high.
- With a constant `rsp_ready=0`, at most 2 operands are in flight. The third request sees `req_ready=0`.
- `req_ready` depends combinationally on `req_valid` and `rsp_ready`.
- There is no combinational path from `req_p` to any output.
- Fairness: a continuously valid requester is granted within NREQ accepted handshakes.

## Structure
Package `posit_types` owns:
- `posit64_t` and `sign_t`.
- Constants `POSIT64_ZERO` (0x0) and `POSIT64_NAR` (0x8000_0000_0000_0000).
- The response struct `posit64_decoded_t` (sign, regime, exponent, fraction, zero, nar).

Sub-modules:
- `rr_arbiter`, parameterised by N: inputs `req` and `prio`, plus an enable; outputs a one-hot grant and its encoded index. It is reusable by later shared units.
- The decode between S1 and S2 is the existing `posit_variable_decode` instantiated with width 64 and `ES`. No decode logic is duplicated in this block.

## Test plan
1. **Single request.** NREQ=4, `req_valid`=0b0100, `req_p[2]`=0x4000_0000_0000_0000, `rsp_ready`=1. Expect `req_ready`=0b0100, then 2 edges later `rsp_valid`=1, `rsp_id`=2, sign 0, regime 0, exponent 0, fraction 0.
2. **Regime values.** Operands 0x6000_0000_0000_0000 and 0x2000_0000_0000_0000 give regime +1 and −1 respectively. 0x0 gives `rsp_zero`=1; 0x8000_0000_0000_0000 gives `rsp_nar`=1 with sign 1.
3. **Fairness.** All four `req_valid` held high for 8 cycles with `rsp_ready`=1. Expect `rsp_id` sequence 0,1,2,3,0,1,2,3 with back-to-back responses.
4. **Backpressure.** `rsp_ready`=0 for 5 cycles with requester 1 always valid. Expect exactly 2 accepts, then `req_ready`=0 and `rsp_*` stable. On release, expect responses in acceptance order with no loss or duplication.
5. **Flush.** Assert `flush` with both stages full and `prio`=3. Expect `rsp_valid`=0 next cycle, no `req_ready` in the flush cycle, and the next grant goes to requester 3 when valid.
6. **Reset mid-stream.** Pulse `rst` one cycle during continuous traffic. Expect all outputs 0 and `prio`=0 the following cycle, and no response for the dropped operands.

Source files
------------

// File: rtl/posit_types.sv
// Shared posit64 type definitions used by the decode arbiter and the arithmetic units.
package posit_types;

   typedef logic [63:0] posit64_t;

   typedef enum logic {
      SIGN_POS = 1'b0,
      SIGN_NEG = 1'b1
   } sign_t;

   localparam posit64_t POSIT64_ZERO = 64'h0000_0000_0000_0000;
   localparam posit64_t POSIT64_NAR  = 64'h8000_0000_0000_0000;

   typedef struct packed {
      sign_t              sign;
      logic signed [63:0] regime;
      logic signed [63:0] exponent;
      logic [63:0]        fraction;
      logic               zero;
      logic               nar;
   } posit64_decoded_t;

endpackage

// File: rtl/posit64_decode_arbiter_if.sv
// Requester and response bus of the shared posit64 decoder.
interface posit64_decode_arbiter_if #(
   parameter int unsigned NREQ = 4
) ();
   localparam int unsigned IDW = $clog2(NREQ);

   logic [NREQ-1:0]                    req_valid;
   logic [NREQ-1:0]                    req_ready;
   posit_types::posit64_t [NREQ-1:0]   req_p;
   logic                               rsp_valid;
   logic                               rsp_ready;
   logic [IDW-1:0]                     rsp_id;
   posit_types::sign_t                 rsp_sign;
   logic signed [63:0]                 rsp_regime;
   logic signed [63:0]                 rsp_exponent;
   logic [63:0]                        rsp_fraction;
   logic                               rsp_zero;
   logic                               rsp_nar;

   modport slave (
      input  req_valid, req_p, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sign, rsp_regime,
             rsp_exponent, rsp_fraction, rsp_zero, rsp_nar
   );

   modport master (
      output req_valid, req_p, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sign, rsp_regime,
             rsp_exponent, rsp_fraction, rsp_zero, rsp_nar
   );
endinterface

// File: rtl/posit_variable_decode.sv
// Combinational posit decode of width N with ES exponent bits; zero/NaR flatten to 0 fields.
module posit_variable_decode #(
   parameter int unsigned N  = 64,
   parameter int unsigned ES = 2
) (
   input  logic [N-1:0]        p,
   output logic                sign,
   output logic signed [N-1:0] regime,
   output logic signed [N-1:0] exponent,
   output logic [N-1:0]        fraction,
   output logic                zero,
   output logic                nar
);
   localparam int unsigned RW = $clog2(N) + 1;

   logic [N-1:0]        x, v, t, shifted;
   logic [RW-1:0]       run;
   logic                done;
   logic signed [N-1:0] rext;

   always_comb begin
      zero = (p == '0);
      nar  = (p == {1'b1, {(N-1){1'b0}}});
      sign = p[N-1];
      x    = p[N-1] ? -p : p;
      v    = x << 1;
      // Regime run length: count bits equal to the leading body bit, stop at the terminator.
      run  = '0;
      done = 1'b0;
      t    = v;
      for (int unsigned i = 0; i < N; i++) begin
         if (!done) begin
            if (t[N-1] == v[N-1]) run = run + RW'(1);
            else                  done = 1'b1;
         end
         t = t << 1;
      end
      rext     = $signed(N'(run));
      regime   = v[N-1] ? rext - 1 : -rext;
      shifted  = v << (run + RW'(1));
      exponent = shifted >> (N - ES);
      fraction = shifted << ES;
      if (zero || nar) begin
         regime   = '0;
         exponent = '0;
         fraction = '0;
      end
   end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after prio wins, gated by en.
module rr_arbiter #(
   parameter int unsigned N = 4,
   localparam int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] prio,
   input  logic          en,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx
);
   logic [IW-1:0] j;
   logic          found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = '0;
      for (int unsigned i = 0; i < N; i++) begin
         j = IW'((32'(prio) + i) % N);
         if (en && !found && req[j]) begin
            grant[j] = 1'b1;
            idx      = j;
            found    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/posit64_decode_arbiter.sv
// Round-robin shared posit64 decoder: operand register S1, decode, output register S2.
module posit64_decode_arbiter
   import posit_types::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned ES   = 2
) (
   input logic                      clk,
   input logic                      rst,
   input logic                      flush,
   posit64_decode_arbiter_if.slave  bus
);
   localparam int unsigned IDW = $clog2(NREQ);

   logic             s1_valid;
   posit64_t         s1_p;
   logic [IDW-1:0]   s1_id;
   logic [IDW-1:0]   prio;
   logic [IDW-1:0]   gidx;
   logic [NREQ-1:0]  grant;
   logic             s1_take, s2_take, hs;
   logic             rsp_valid_q;
   logic [IDW-1:0]   rsp_id_q;
   posit64_decoded_t s2, dec;

   logic                d_sign, d_zero, d_nar;
   logic signed [63:0]  d_regime, d_exponent;
   logic [63:0]         d_fraction;

   assign s2_take = !rsp_valid_q || bus.rsp_ready;
   assign s1_take = !s1_valid || s2_take;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req   (bus.req_valid),
      .prio  (prio),
      .en    (s1_take && !flush && !rst),
      .grant (grant),
      .idx   (gidx)
   );

   assign bus.req_ready = grant;
   assign hs            = |grant;

   posit_variable_decode #(.N(64), .ES(ES)) u_dec (
      .p        (s1_p),
      .sign     (d_sign),
      .regime   (d_regime),
      .exponent (d_exponent),
      .fraction (d_fraction),
      .zero     (d_zero),
      .nar      (d_nar)
   );

   always_comb begin
      dec = '{sign: sign_t'(d_sign), regime: d_regime, exponent: d_exponent,
              fraction: d_fraction, zero: d_zero, nar: d_nar};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s1_p        <= '0;
         s1_id       <= '0;
         prio        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         s2          <= '0;
      end else if (flush) begin
         s1_valid    <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         if (s2_take) begin
            rsp_valid_q <= s1_valid;
            if (s1_valid) begin
               s2       <= dec;
               rsp_id_q <= s1_id;
            end
         end
         if (s1_take) begin
            s1_valid <= hs;
            if (hs) begin
               s1_p  <= bus.req_p[gidx];
               s1_id <= gidx;
               prio  <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + IDW'(1);
            end
         end
      end
   end

   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_id       = rsp_id_q;
   assign bus.rsp_sign     = s2.sign;
   assign bus.rsp_regime   = s2.regime;
   assign bus.rsp_exponent = s2.exponent;
   assign bus.rsp_fraction = s2.fraction;
   assign bus.rsp_zero     = s2.zero;
   assign bus.rsp_nar      = s2.nar;
endmodule

// File: tb/tb_posit64_decode_arbiter.sv
// Scoreboard bench for posit64_decode_arbiter: directed operands with hand-decoded expectations.
module tb_posit64_decode_arbiter;
   import posit_types::*;

   localparam int unsigned NREQ = 4;

   typedef struct packed {
      logic [1:0]       id;
      posit64_decoded_t d;
   } exp_t;

   logic clk = 1'b0;
   logic rst, flush;
   always #5 clk = ~clk;

   posit64_decode_arbiter_if #(.NREQ(NREQ)) bus ();

   posit64_decode_arbiter #(.NREQ(NREQ), .ES(2)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   posit64_t         vp [10];
   posit64_decoded_t ve [10];
   posit64_decoded_t exp_tbl [NREQ];
   exp_t             q [$];
   exp_t             e, held;
   posit64_decoded_t cur_d;

   int   n_checks = 0;
   int   n_pass   = 0;
   bit   m_s1v = 0, m_s2v = 0, t1, t2;
   int   m_prio = 0;
   int   g;
   logic [3:0] er;
   bit   rst_prev = 0, hold_prev = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, expv);
   endtask

   function automatic posit64_decoded_t mk(input logic s, input longint r, input longint x,
                                            input logic [63:0] f, input logic z, input logic n);
      posit64_decoded_t d;
      d.sign     = sign_t'(s);
      d.regime   = r;
      d.exponent = x;
      d.fraction = f;
      d.zero     = z;
      d.nar      = n;
      return d;
   endfunction

   // Monitor: predicts grants and pipeline occupancy, pops the scoreboard on each consumed response.
   always @(negedge clk) begin
      cur_d = '{sign: bus.rsp_sign, regime: bus.rsp_regime, exponent: bus.rsp_exponent,
                fraction: bus.rsp_fraction, zero: bus.rsp_zero, nar: bus.rsp_nar};
      if (rst_prev)
         check("reset_outputs", {bus.rsp_valid, bus.rsp_id, cur_d}, '0);

      t2 = !m_s2v || bus.rsp_ready;
      t1 = !m_s1v || t2;
      g  = -1;
      er = '0;
      if (!rst && !flush && t1)
         for (int i = 0; i < NREQ; i++)
            if (g < 0 && bus.req_valid[(m_prio + i) % NREQ]) g = (m_prio + i) % NREQ;
      if (g >= 0) er[g] = 1'b1;
      check("req_ready", bus.req_ready, er);
      check("rsp_valid", bus.rsp_valid, m_s2v);
      if (hold_prev) check("stall_hold", {bus.rsp_id, cur_d}, held);

      if (bus.rsp_valid && bus.rsp_ready && !rst) begin
         if (q.size() == 0) check("rsp_unexpected", q.size(), 1);
         else begin
            e = q.pop_front();
            check("rsp_data", {bus.rsp_id, cur_d}, e);
         end
      end
      hold_prev = bus.rsp_valid && !bus.rsp_ready && !rst && !flush;
      held      = '{id: bus.rsp_id, d: cur_d};

      if (rst) begin
         m_s1v = 0; m_s2v = 0; m_prio = 0;
         q.delete();
      end else if (flush) begin
         m_s1v = 0; m_s2v = 0;
         q.delete();
      end else begin
         if (t2) m_s2v = m_s1v;
         if (t1) begin
            m_s1v = (g >= 0);
            if (g >= 0) begin
               q.push_back('{id: 2'(g), d: exp_tbl[g]});
               m_prio = (g == NREQ - 1) ? 0 : g + 1;
            end
         end
      end
      rst_prev = rst;
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic setreq(input int r, input int v);
      bus.req_p[r] = vp[v];
      exp_tbl[r]   = ve[v];
   endtask

   initial begin
      vp[0] = 64'h4000_0000_0000_0000; ve[0] = mk(0,   0, 0, 64'h0, 0, 0);
      vp[1] = 64'h6000_0000_0000_0000; ve[1] = mk(0,   1, 0, 64'h0, 0, 0);
      vp[2] = 64'h2000_0000_0000_0000; ve[2] = mk(0,  -1, 0, 64'h0, 0, 0);
      vp[3] = 64'h0000_0000_0000_0000; ve[3] = mk(0,   0, 0, 64'h0, 1, 0);
      vp[4] = 64'h8000_0000_0000_0000; ve[4] = mk(1,   0, 0, 64'h0, 0, 1);
      vp[5] = 64'h4C00_0000_0000_0000; ve[5] = mk(0,   0, 1, 64'h8000_0000_0000_0000, 0, 0);
      vp[6] = 64'hC000_0000_0000_0000; ve[6] = mk(1,   0, 0, 64'h0, 0, 0);
      vp[7] = 64'h7FFF_FFFF_FFFF_FFFF; ve[7] = mk(0,  62, 0, 64'h0, 0, 0);
      vp[8] = 64'h0000_0000_0000_0001; ve[8] = mk(0, -62, 0, 64'h0, 0, 0);
      vp[9] = 64'h5A00_0000_0000_0000; ve[9] = mk(0,   0, 3, 64'h4000_0000_0000_0000, 0, 0);

      rst = 1'b1;
      flush = 1'b0;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b0;
      for (int r = 0; r < NREQ; r++) setreq(r, 0);
      cyc(3);
      rst = 1'b0;
      cyc(1);

      // single request from requester 2
      setreq(2, 0);
      bus.rsp_ready = 1'b1;
      bus.req_valid = 4'b0100;
      cyc(1);
      bus.req_valid = '0;
      cyc(4);

      // decode vectors, one requester at a time
      for (int v = 1; v < 10; v++) begin
         setreq(v % NREQ, v);
         bus.req_valid = 4'(1 << (v % NREQ));
         cyc(1);
      end
      bus.req_valid = '0;
      cyc(4);

      // backpressure on requester 1
      setreq(1, 5);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b0010;
      cyc(1);
      setreq(1, 9);
      cyc(4);
      bus.rsp_ready = 1'b1;
      cyc(1);
      bus.req_valid = '0;
      cyc(4);

      // fill both stages leaving prio at 3, then flush
      bus.rsp_ready = 1'b0;
      setreq(1, 1);
      bus.req_valid = 4'b0010;
      cyc(1);
      setreq(2, 2);
      bus.req_valid = 4'b0100;
      cyc(1);
      setreq(0, 0);
      setreq(3, 7);
      bus.req_valid = 4'b1001;
      flush = 1'b1;
      cyc(1);
      flush = 1'b0;
      cyc(1);
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      cyc(4);

      // reset pulse during continuous traffic, then fairness from prio 0
      for (int r = 0; r < NREQ; r++) setreq(r, 5 + r);
      bus.req_valid = 4'b1111;
      cyc(3);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      for (int r = 0; r < NREQ; r++) setreq(r, r);
      cyc(8);
      bus.req_valid = '0;

      for (int i = 0; i < 50 && q.size() != 0; i++) cyc(1);
      cyc(2);
      check("drain_empty", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
